// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
// Sequencer for the 3x3 line buffer in the VGG16 convolution path. On an
// accepted start it walks every channel of the input feature map in raster
// order and issues one memory read per pixel. Each returned pixel is pushed
// into the line buffer, and the buffer is cleared before each channel. The
// block also flags the cycles in which the line buffer holds a complete 3x3
// window. Because the convolution uses no padding, those are the windows
// whose bottom-right pixel has row >= 2 and col >= 2.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         one-cycle request to begin a pass (ignored while busy)
//   cfg_base      base address of channel 0, sampled on an accepted start
//   cfg_num_ch    channel count, sampled on an accepted start (0 means 1)
//   hold          pauses new memory reads; pixels already in flight still land
//   mem_rd_en     memory read strobe
//   mem_addr      memory read address
//   mem_rdata     read data, valid exactly one cycle after mem_rd_en
//   lb_clear      one-cycle line buffer clear, once before each channel
//   lb_valid_in   pixel push strobe to the line buffer
//   lb_data       pixel to the line buffer (mem_rdata passed straight through)
//   win_valid     line buffer outputs hold a valid 3x3 window this cycle
//   win_row       window top-left row
//   win_col       window top-left column
//   ch_idx        channel of the current window
//   ch_first      the window belongs to the first channel
//   ch_last       the window belongs to the last channel
//   busy          high from an accepted start until done
//   done          one-cycle pulse at the end of the pass
module conv_window_ctrl #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CH_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CH_W-1:0]   cfg_num_ch,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_clear,
  output logic              lb_valid_in,
  output logic [DATA_W-1:0] lb_data,
  output logic              win_valid,
  output logic [7:0]        win_row,
  output logic [7:0]        win_col,
  output logic [CH_W-1:0]   ch_idx,
  output logic              ch_first,
  output logic              ch_last,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] LAST_C = 8'(IMG_W - 1);
  localparam logic [7:0] LAST_R = 8'(IMG_H - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        r;
  logic [7:0]        c;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   num_ch;
  logic              drain_cnt;

  // Tag of the pixel read in the previous cycle, arriving with its data.
  logic              p1_valid;
  logic [7:0]        p1_r;
  logic [7:0]        p1_c;
  logic [CH_W-1:0]   p1_ch;
  logic              win_ok;

  assign mem_rd_en   = (state == S_FETCH) && !hold;
  assign mem_addr    = addr;
  assign lb_clear    = (state == S_CLEAR);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign lb_valid_in = p1_valid;
  assign lb_data     = mem_rdata;

  // Channels are stored back to back, so a running address reproduces
  // base + ch*W*H + r*W + c (mod 2^ADDR_W) without any multipliers.
  // The two drain cycles let the last pixel push and its window flag
  // retire before the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      r         <= '0;
      c         <= '0;
      ch        <= '0;
      num_ch    <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr   <= cfg_base;
            num_ch <= (cfg_num_ch == '0) ? CH_W'(1) : cfg_num_ch;
            ch     <= '0;
            r      <= '0;
            c      <= '0;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r     <= '0;
          c     <= '0;
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (!hold) begin
            addr <= addr + ADDR_W'(1);
            if (c == LAST_C) begin
              c <= '0;
              if (r == LAST_R) begin
                r         <= '0;
                drain_cnt <= 1'b0;
                state     <= S_DRAIN;
              end else begin
                r <= r + 8'd1;
              end
            end else begin
              c <= c + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            if (ch == num_ch - CH_W'(1)) begin
              state <= S_DONE;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= S_CLEAR;
            end
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign win_ok = p1_valid && (p1_r >= 8'd2) && (p1_c >= 8'd2);

  // The read tag travels one stage with the read data (push), then a second
  // stage to the window flag. The line buffer presents the window one cycle
  // after the pixel that completes it. The coordinates only update on a
  // valid window, so they stay steady between windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid  <= 1'b0;
      p1_r      <= '0;
      p1_c      <= '0;
      p1_ch     <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      ch_idx    <= '0;
      ch_first  <= 1'b0;
      ch_last   <= 1'b0;
    end else begin
      p1_valid  <= mem_rd_en;
      p1_r      <= r;
      p1_c      <= c;
      p1_ch     <= ch;
      win_valid <= win_ok;
      ch_first  <= win_ok && (p1_ch == '0);
      ch_last   <= win_ok && (p1_ch == num_ch - CH_W'(1));
      if (win_ok) begin
        win_row <= p1_r - 8'd2;
        win_col <= p1_c - 8'd2;
        ch_idx  <= p1_ch;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl
// Scoreboard bench for conv_window_ctrl (5x5 image). Each directed pass
// pushes its hand-derived read addresses and windows into queues. A monitor
// pops and compares these on every read strobe and window strobe. Optional
// cycle stamps are relative to the cycle in which start was driven.
module tb_conv_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_base;
  logic [8:0]  cfg_num_ch;
  logic        hold;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        lb_clear;
  logic        lb_valid_in;
  logic [31:0] lb_data;
  logic        win_valid;
  logic [7:0]  win_row;
  logic [7:0]  win_col;
  logic [8:0]  ch_idx;
  logic        ch_first;
  logic        ch_last;
  logic        busy;
  logic        done;

  conv_window_ctrl #(.IMG_W(5), .IMG_H(5), .ADDR_W(16), .DATA_W(32), .CH_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_num_ch(cfg_num_ch),
    .hold(hold), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .lb_clear(lb_clear), .lb_valid_in(lb_valid_in), .lb_data(lb_data),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .ch_idx(ch_idx),
    .ch_first(ch_first), .ch_last(ch_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    int          cyc;
  } rd_t;

  typedef struct {
    logic [7:0] row;
    logic [7:0] col;
    logic [8:0] ch;
    logic       first;
    logic       last;
    int         cyc;
  } win_t;

  rd_t  rd_q[$];
  win_t win_q[$];

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int t0 = 0;
  int clear_cnt, push_cnt, done_cnt, overlap_cnt, done_rel;
  logic        pend_valid;
  logic [15:0] pend_addr;

  // Memory model: the data word encodes the address it came from.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rdata <= {16'hA5A5, mem_addr};
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    nvec++;
    if (actual !== expected) begin
      nfail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or window.
  always @(negedge clk) begin
    if (rst) begin
      pend_valid = 1'b0;
    end else begin
      if (lb_valid_in || pend_valid) begin
        checkOutput("push_present", lb_valid_in, pend_valid);
        if (lb_valid_in && pend_valid)
          checkOutput("lb_data", lb_data, {16'hA5A5, pend_addr});
      end
      pend_valid = 1'b0;
      if (mem_rd_en) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_read", 1, 0);
        end else begin
          rd_t e;
          e = rd_q.pop_front();
          checkOutput("rd_addr", mem_addr, e.addr);
          if (e.cyc >= 0) checkOutput("rd_cycle", cyc - t0, e.cyc);
          pend_valid = 1'b1;
          pend_addr  = e.addr;
        end
      end
      if (win_valid) begin
        if (win_q.size() == 0) begin
          checkOutput("unexpected_window", 1, 0);
        end else begin
          win_t w;
          w = win_q.pop_front();
          checkOutput("win_row", win_row, w.row);
          checkOutput("win_col", win_col, w.col);
          checkOutput("ch_idx", ch_idx, w.ch);
          checkOutput("ch_first", ch_first, w.first);
          checkOutput("ch_last", ch_last, w.last);
          if (w.cyc >= 0) checkOutput("win_cycle", cyc - t0, w.cyc);
        end
      end
      if (lb_valid_in) push_cnt++;
      if (lb_clear) clear_cnt++;
      if (lb_clear && (lb_valid_in || win_valid)) overlap_cnt++;
      if (done) begin
        done_cnt++;
        done_rel = cyc - t0;
      end
    end
  end

  // Queue the expected reads and windows for one pass, then issue start.
  task automatic applyStimulus(input logic [15:0] base, input logic [8:0] nch, input bit timed);
    int n;
    n = (nch == 0) ? 1 : int'(nch);
    clear_cnt = 0; push_cnt = 0; done_cnt = 0; overlap_cnt = 0; done_rel = -1;
    for (int ch = 0; ch < n; ch++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          rd_t  e;
          win_t w;
          int   rc;
          rc     = 2 + ch * 28 + r * 5 + c;
          e.addr = 16'(int'(base) + ch * 25 + r * 5 + c);
          e.cyc  = timed ? rc : -1;
          rd_q.push_back(e);
          if (r >= 2 && c >= 2) begin
            w.row   = 8'(r - 2);
            w.col   = 8'(c - 2);
            w.ch    = 9'(ch);
            w.first = (ch == 0);
            w.last  = (ch == n - 1);
            w.cyc   = timed ? rc + 2 : -1;
            win_q.push_back(w);
          end
        end
    @(posedge clk); #1;
    cfg_base = base; cfg_num_ch = nch; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for the end of the pass, then check the per-pass totals.
  task automatic waitPass(input int nch_eff, input int exp_done_rel);
    for (int i = 0; i < 400 && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) checkOutput("done_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("done_count", done_cnt, 1);
    checkOutput("clear_count", clear_cnt, nch_eff);
    checkOutput("push_count", push_cnt, 25 * nch_eff);
    checkOutput("clear_overlap", overlap_cnt, 0);
    checkOutput("reads_left", rd_q.size(), 0);
    checkOutput("windows_left", win_q.size(), 0);
    checkOutput("busy_after", busy, 0);
    if (exp_done_rel >= 0) checkOutput("done_cycle", done_rel, exp_done_rel);
    rd_q.delete();
    win_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_num_ch = '0; hold = 1'b0;
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_en", mem_rd_en, 0);
    checkOutput("rst_win_valid", win_valid, 0);
    checkOutput("rst_lb_clear", lb_clear, 0);
    // start together with reset must be lost
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("rst_wins_start", busy, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] pass 1: single channel, base 0");
    applyStimulus(16'd0, 9'd1, 1'b1);
    waitPass(1, 29);

    $display("[TB] pass 2: three channels, base 100");
    applyStimulus(16'd100, 9'd3, 1'b1);
    waitPass(3, 85);

    $display("[TB] pass 3: hold for four cycles after the 7th read");
    applyStimulus(16'd0, 9'd1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    hold = 1'b1;
    #1;
    checkOutput("hold_rd_en_c9", mem_rd_en, 0);
    checkOutput("hold_push_c9", lb_valid_in, 1);
    @(posedge clk); #1;
    checkOutput("hold_rd_en_c10", mem_rd_en, 0);
    checkOutput("hold_push_c10", lb_valid_in, 0);
    repeat (3) @(posedge clk);
    #1;
    hold = 1'b0;
    waitPass(1, 33);

    $display("[TB] pass 4: zero channels treated as one");
    applyStimulus(16'd40, 9'd0, 1'b1);
    waitPass(1, 29);

    $display("[TB] pass 5: reset at the 10th read, then restart");
    applyStimulus(16'd0, 9'd1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_rd_en", mem_rd_en, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_addr", mem_addr, 0);
    checkOutput("abort_push", lb_valid_in, 0);
    checkOutput("abort_reads_done", 25 - rd_q.size(), 9);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_q.delete();
    win_q.delete();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_cnt, 0);
    applyStimulus(16'd7, 9'd1, 1'b1);
    waitPass(1, 29);

    $display("[TB] pass 6: start while busy is ignored");
    applyStimulus(16'd200, 9'd1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; cfg_base = 16'd500; cfg_num_ch = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    waitPass(1, 29);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
